// File: rtl/uart_msg_tx_pkg.sv
// Shared types and framing helpers for the game-link UART message transmitter.
// Frames are SYNC, type, payload (0-3 bytes) and an XOR checksum over type and payload.
package uart_msg_tx_pkg;

   typedef enum logic [1:0] {
      BALL         = 2'd0,
      MISS         = 2'd1,
      NEW_GAME     = 2'd2,
      NEW_GAME_ACK = 2'd3
   } msg_type_t;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      WAIT_CTS = 3'd1,
      START    = 3'd2,
      DATA     = 3'd3,
      PARITY   = 3'd4,
      STOP     = 3'd5
   } tx_state_t;

   localparam logic [7:0] SYNC_BYTE = 8'hA5;

   localparam int unsigned BALL_LEN         = 3;
   localparam int unsigned MISS_LEN         = 2;
   localparam int unsigned NEW_GAME_LEN     = 1;
   localparam int unsigned NEW_GAME_ACK_LEN = 0;

   // sync + type + checksum wrapped around every payload
   localparam int unsigned FRAME_OVERHEAD = 3;
   localparam int unsigned IDX_W          = 3;

   typedef struct packed {
      msg_type_t  mtype;
      logic [8:0] ball_y;
      logic [3:0] velocity_x;
      logic [3:0] velocity_y;
      logic [4:0] my_score;
      logic [4:0] your_score;
      logic       you_should_serve;
      logic       you_serve_first;
   } msg_t;

   function automatic logic [IDX_W-1:0] frame_len(input msg_type_t t);
      logic [IDX_W-1:0] len;
      case (t)
         BALL:     len = IDX_W'(BALL_LEN + FRAME_OVERHEAD);
         MISS:     len = IDX_W'(MISS_LEN + FRAME_OVERHEAD);
         NEW_GAME: len = IDX_W'(NEW_GAME_LEN + FRAME_OVERHEAD);
         default:  len = IDX_W'(NEW_GAME_ACK_LEN + FRAME_OVERHEAD);
      endcase
      return len;
   endfunction

   // Byte at position idx of the frame for message m; the last position is the checksum.
   function automatic logic [7:0] frame_byte(input msg_t m, input logic [IDX_W-1:0] idx);
      logic [7:0]       typ;
      logic [7:0]       pay0;
      logic [7:0]       pay1;
      logic [7:0]       pay2;
      logic [7:0]       chk;
      logic [7:0]       res;
      logic [IDX_W-1:0] last;
      typ  = {6'b0, m.mtype};
      pay0 = 8'h00;
      pay1 = 8'h00;
      pay2 = 8'h00;
      case (m.mtype)
         BALL: begin
            pay0 = {7'b0, m.ball_y[8]};
            pay1 = m.ball_y[7:0];
            pay2 = {m.velocity_x, m.velocity_y};
         end
         MISS: begin
            pay0 = {2'b0, m.you_should_serve, m.my_score};
            pay1 = {3'b0, m.your_score};
         end
         NEW_GAME: pay0 = {7'b0, m.you_serve_first};
         default: ;
      endcase
      // unused payload slots stay zero so they drop out of the XOR
      chk  = typ ^ pay0 ^ pay1 ^ pay2;
      last = frame_len(m.mtype) - IDX_W'(1);
      if (idx == IDX_W'(0))      res = SYNC_BYTE;
      else if (idx == IDX_W'(1)) res = typ;
      else if (idx == last)      res = chk;
      else if (idx == IDX_W'(2)) res = pay0;
      else if (idx == IDX_W'(3)) res = pay1;
      else                       res = pay2;
      return res;
   endfunction

endpackage

// File: rtl/uart_msg_tx_byte_tx.sv
// Single-byte UART serialiser with per-byte clear-to-send gating and optional even parity.
// done_c flags the last cycle of the final stop bit so the next byte can follow without a gap.
module uart_byte_tx
   import uart_msg_tx_pkg::*;
#(
   parameter int unsigned DIV       = 8,
   parameter int unsigned STOP_BITS = 1,
   parameter int unsigned PARITY_EN = 0
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       go,
   input  logic [7:0] data,
   input  logic       cts_n,
   output logic       busy,
   output logic       done_c,
   output logic       txd
);

   localparam int unsigned CNT_W = (DIV > 2) ? $clog2(DIV) : 1;

   tx_state_t        state;
   logic [CNT_W-1:0] baud_cnt;
   logic [2:0]       bit_cnt;
   logic [7:0]       shreg;
   logic             parity;
   logic             bit_end_c;
   logic             in_bit_c;

   assign in_bit_c  = (state == START) || (state == DATA) || (state == PARITY) || (state == STOP);
   assign bit_end_c = (baud_cnt == CNT_W'(DIV - 1));
   assign done_c    = (state == STOP) && bit_end_c && (bit_cnt == 3'(STOP_BITS - 1));

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         baud_cnt <= '0;
         bit_cnt  <= '0;
         shreg    <= '0;
         parity   <= 1'b0;
         busy     <= 1'b0;
         txd      <= 1'b1;
      end else begin
         // every line bit is held for exactly DIV cycles
         if (in_bit_c) begin
            baud_cnt <= bit_end_c ? '0 : baud_cnt + 1'b1;
         end

         case (state)
            IDLE: begin
               txd <= 1'b1;
               if (go) begin
                  shreg  <= data;
                  parity <= ^data;
                  busy   <= 1'b1;
                  state  <= WAIT_CTS;
               end
            end

            WAIT_CTS: begin
               // the peer may hold us off indefinitely between bytes
               if (!cts_n) begin
                  state    <= START;
                  txd      <= 1'b0;
                  baud_cnt <= '0;
               end
            end

            START: begin
               if (bit_end_c) begin
                  bit_cnt <= '0;
                  txd     <= shreg[0];
                  shreg   <= shreg >> 1;
                  state   <= DATA;
               end
            end

            DATA: begin
               if (bit_end_c) begin
                  if (bit_cnt == 3'd7) begin
                     bit_cnt <= '0;
                     if (PARITY_EN != 0) begin
                        txd   <= parity;
                        state <= PARITY;
                     end else begin
                        txd   <= 1'b1;
                        state <= STOP;
                     end
                  end else begin
                     bit_cnt <= bit_cnt + 3'd1;
                     txd     <= shreg[0];
                     shreg   <= shreg >> 1;
                  end
               end
            end

            PARITY: begin
               if (bit_end_c) begin
                  txd   <= 1'b1;
                  state <= STOP;
               end
            end

            STOP: begin
               if (bit_end_c) begin
                  if (done_c) begin
                     bit_cnt <= '0;
                     if (go) begin
                        shreg  <= data;
                        parity <= ^data;
                        state  <= WAIT_CTS;
                     end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                     end
                  end else begin
                     bit_cnt <= bit_cnt + 3'd1;
                  end
               end
            end

            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               txd   <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: rtl/uart_msg_tx.sv
// Game-link message transmitter: latches one message, frames it and streams the bytes
// through uart_byte_tx back to back, pulsing message_sent after the last stop bit.
module uart_msg_tx
   import uart_msg_tx_pkg::*;
#(
   parameter int unsigned CLK_HZ    = 50000000,
   parameter int unsigned BAUD      = 115200,
   parameter int unsigned STOP_BITS = 1,
   parameter int unsigned PARITY_EN = 0
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       send_new_message,
   input  logic [1:0] msg_type,
   input  logic [8:0] ball_y_tx,
   input  logic [3:0] velocity_x_tx,
   input  logic [3:0] velocity_y_tx,
   input  logic [4:0] my_score_tx,
   input  logic [4:0] your_score_tx,
   input  logic       you_should_serve_tx,
   input  logic       you_serve_first_tx,
   input  logic       cts_n,
   output logic       ready,
   output logic       message_sent,
   output logic       UART_TXD
);

   localparam int unsigned DIV = CLK_HZ / BAUD;

   msg_t             msg_q;
   logic [IDX_W-1:0] idx_q;

   logic             accept_c;
   logic             last_byte_c;
   logic             byte_go_c;
   logic [7:0]       byte_data_c;
   logic             byte_busy;
   logic             byte_done_c;

   assign accept_c    = send_new_message && ready && !byte_busy;
   assign last_byte_c = (idx_q == frame_len(msg_q.mtype) - IDX_W'(1));

   // first byte is always SYNC, so it can be issued straight from the request
   assign byte_go_c   = accept_c || (byte_done_c && !last_byte_c);
   assign byte_data_c = ready ? SYNC_BYTE : frame_byte(msg_q, idx_q + IDX_W'(1));

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         ready        <= 1'b1;
         message_sent <= 1'b0;
         msg_q        <= '0;
         idx_q        <= '0;
      end else begin
         message_sent <= 1'b0;
         if (accept_c) begin
            msg_q <= '{
               mtype:            msg_type_t'(msg_type),
               ball_y:           ball_y_tx,
               velocity_x:       velocity_x_tx,
               velocity_y:       velocity_y_tx,
               my_score:         my_score_tx,
               your_score:       your_score_tx,
               you_should_serve: you_should_serve_tx,
               you_serve_first:  you_serve_first_tx
            };
            idx_q <= '0;
            ready <= 1'b0;
         end else if (byte_done_c) begin
            if (last_byte_c) begin
               ready        <= 1'b1;
               message_sent <= 1'b1;
            end else begin
               idx_q <= idx_q + IDX_W'(1);
            end
         end
      end
   end

   uart_byte_tx #(
      .DIV       (DIV),
      .STOP_BITS (STOP_BITS),
      .PARITY_EN (PARITY_EN)
   ) u_byte_tx (
      .clock  (clock),
      .reset  (reset),
      .go     (byte_go_c),
      .data   (byte_data_c),
      .cts_n  (cts_n),
      .busy   (byte_busy),
      .done_c (byte_done_c),
      .txd    (UART_TXD)
   );

endmodule
